// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with prioritised writes, bypass and clear sequencer
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*WIDTH-1:0] rdata,
    input  logic                   we0,
    input  logic [AW-1:0]          waddr0,
    input  logic [WIDTH-1:0]       wdata0,
    input  logic                   we1,
    input  logic [AW-1:0]          waddr1,
    input  logic [WIDTH-1:0]       wdata1,
    output logic                   busy
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic            wv0, wv1;

    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    function automatic logic addr_writable(input logic [AW-1:0] a);
        return addr_in_range(a) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_CLEAR: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end
            end
            S_RUN: begin
                if (clr) begin
                    state_nx = S_CLEAR;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_CLEAR;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign busy = (state == S_CLEAR);

    // Only writes that will really commit are marked valid, so the bypass never forwards dropped data.
    assign wv0 = rst_n && !busy && !clr && we0 && addr_writable(waddr0);
    assign wv1 = rst_n && !busy && !clr && we1 && addr_writable(waddr1);

    always_ff @(posedge clk) begin
        if (rst_n && busy) begin
            mem[cnt] <= '0;
        end else begin
            if (wv0) mem[waddr0] <= wdata0;
            if (wv1) mem[waddr1] <= wdata1;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        rdata = '0;
        ra    = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = raddr[i*AW +: AW];
            if (busy || !addr_in_range(ra)) begin
                rdata[i*WIDTH +: WIDTH] = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rdata[i*WIDTH +: WIDTH] = '0;
            end else if (wv1 && (waddr1 == ra)) begin
                rdata[i*WIDTH +: WIDTH] = wdata1;
            end else if (wv0 && (waddr0 == ra)) begin
                rdata[i*WIDTH +: WIDTH] = wdata0;
            end else begin
                rdata[i*WIDTH +: WIDTH] = mem[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp (32 ZERO_REG=1, 32 ZERO_REG=0, 20 entries)
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic [9:0]  raddr;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [63:0] rd_m, rd_z, rd_20;
    logic        busy_m, busy_z, busy_20;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        int          sel;
        int          port;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .AW(5), .NREAD(2), .ZERO_REG(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .clr(clr), .raddr(raddr), .rdata(rd_m),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .busy(busy_m));

    regfile_mp #(.WIDTH(32), .DEPTH(32), .AW(5), .NREAD(2), .ZERO_REG(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .clr(clr), .raddr(raddr), .rdata(rd_z),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .busy(busy_z));

    regfile_mp #(.WIDTH(32), .DEPTH(20), .AW(5), .NREAD(2), .ZERO_REG(1)) dut_20 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .raddr(raddr), .rdata(rd_20),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .busy(busy_20));

    function automatic logic [31:0] get_rd(input int sel, input int port);
        case (sel)
            0:       return rd_m[port*32 +: 32];
            1:       return rd_z[port*32 +: 32];
            2:       return rd_20[port*32 +: 32];
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        raddr = {5'(a1), 5'(a0)};
    endtask

    task automatic expect_rd(input string tag, input int sel, input int port, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.port = port; e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_rd(e.sel, e.port);
            n_chk++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Counts edges until busy on the 32-entry file drops; returns 100 if it never does.
    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy_m && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc, c20;
        rst_n = 1'b0; clr = 1'b0;
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        set_rd(3, 7);

        // Reset held for two edges
        tick(); tick();
        chk_int("rst_busy_m", int'(busy_m), 1);
        chk_int("rst_busy_20", int'(busy_20), 1);
        expect_rd("rst_rd0", 0, 0, 32'h0);
        expect_rd("rst_rd1", 0, 1, 32'h0);
        check_sb();

        // Release and time the clear; a write during it must be dropped
        rst_n = 1'b1;
        cyc = 0; c20 = 0;
        while (busy_m && cyc < 100) begin
            tick();
            cyc++;
            if (!busy_20 && c20 == 0) c20 = cyc;
            if (cyc == 3) begin
                we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hFFFF; set_rd(3, 3);
                expect_rd("clear_rd0", 0, 0, 32'h0);
                check_sb();
            end else if (cyc == 4) begin
                we0 = 1'b0;
            end
        end
        chk_int("clear_len32", cyc, 32);
        chk_int("clear_len20", c20, 20);
        set_rd(3, 3);
        expect_rd("clear_wr_dropped", 0, 0, 32'h0);
        check_sb();

        // Dual write collision: port 1 wins in the bypass and in storage
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA0000;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555FFFF;
        set_rd(7, 7);
        expect_rd("coll_byp0", 0, 0, 32'h5555FFFF);
        expect_rd("coll_byp1", 0, 1, 32'h5555FFFF);
        check_sb();
        tick();
        we0 = 1'b0; we1 = 1'b0;
        expect_rd("coll_mem", 0, 0, 32'h5555FFFF);
        check_sb();

        // Same-cycle bypass then storage
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h12345678; set_rd(5, 7);
        expect_rd("byp5", 0, 0, 32'h12345678);
        expect_rd("byp_other", 0, 1, 32'h5555FFFF);
        check_sb();
        tick();
        we0 = 1'b0;
        expect_rd("mem5", 0, 0, 32'h12345678);
        check_sb();

        // Zero register vs ordinary address 0
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF; set_rd(0, 0);
        expect_rd("zr_byp", 0, 0, 32'h0);
        expect_rd("nozr_byp", 1, 0, 32'hFFFFFFFF);
        check_sb();
        tick();
        we1 = 1'b0;
        expect_rd("zr_mem", 0, 1, 32'h0);
        expect_rd("nozr_mem", 1, 1, 32'hFFFFFFFF);
        check_sb();

        // Non-power-of-two depth: address 25 absent, 19 is last entry
        we0 = 1'b1; waddr0 = 5'd25; wdata0 = 32'h1;
        we1 = 1'b1; waddr1 = 5'd19; wdata1 = 32'hABCD;
        set_rd(19, 25);
        expect_rd("d20_byp19", 2, 0, 32'hABCD);
        expect_rd("d20_rd25", 2, 1, 32'h0);
        check_sb();
        tick();
        we0 = 1'b0; we1 = 1'b0;
        expect_rd("d20_mem19", 2, 0, 32'hABCD);
        expect_rd("d20_mem25", 2, 1, 32'h0);
        expect_rd("d32_mem25", 0, 1, 32'h1);
        check_sb();

        // Back-to-back writes to one address
        we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h1111; set_rd(6, 6);
        tick();
        wdata0 = 32'h2222;
        expect_rd("b2b_byp", 0, 0, 32'h2222);
        check_sb();
        tick();
        we0 = 1'b0;
        expect_rd("b2b_mem", 0, 1, 32'h2222);
        check_sb();

        // Fill 1..31 with their index
        for (int a = 1; a < 32; a++) begin
            we0 = 1'b1; waddr0 = 5'(a); wdata0 = 32'(a);
            tick();
        end
        we0 = 1'b0;
        set_rd(9, 31);
        expect_rd("fill9", 0, 0, 32'd9);
        expect_rd("fill31", 0, 1, 32'd31);
        check_sb();

        // Clear request with a simultaneous write: write dropped and not forwarded
        clr = 1'b1; we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hDEAD;
        expect_rd("clr_no_byp", 0, 0, 32'd9);
        check_sb();
        tick();
        clr = 1'b0; we0 = 1'b0;
        chk_int("clr_busy", int'(busy_m), 1);
        count_busy(cyc);
        chk_int("clr_len", cyc, 32);
        for (int a = 0; a < 32; a += 2) begin
            set_rd(a, a + 1);
            expect_rd($sformatf("post_clr_%0d", a), 0, 0, 32'h0);
            expect_rd($sformatf("post_clr_%0d", a + 1), 0, 1, 32'h0);
            check_sb();
        end

        // Reset in the middle of a clear restarts the count
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk_int("mid_busy", int'(busy_m), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_busy(cyc);
        chk_int("mid_rst_len", cyc, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
